// File: rtl/sm3_ahb_regfile_if.sv
// AHB-Lite bus bundle for the SM3 register file.
// The master drives the address/control/write-data side; the slave returns read data and the response.
interface sm3_ahb_regfile_if #(
  parameter int unsigned HADDR_W = 6
);
  logic               AHB_HSEL;
  logic [1:0]         AHB_HTRANS;
  logic               AHB_HREADY;
  logic               AHB_HWRITE;
  logic [HADDR_W-1:0] AHB_HADDR;
  logic [31:0]        AHB_HWDATA;
  logic [31:0]        AHB_HRDATA;
  logic               AHB_HREADYOUT;
  logic               AHB_HRESP;

  modport master (
    output AHB_HSEL, AHB_HTRANS, AHB_HREADY, AHB_HWRITE, AHB_HADDR, AHB_HWDATA,
    input  AHB_HRDATA, AHB_HREADYOUT, AHB_HRESP
  );

  modport slave (
    input  AHB_HSEL, AHB_HTRANS, AHB_HREADY, AHB_HWRITE, AHB_HADDR, AHB_HWDATA,
    output AHB_HRDATA, AHB_HREADYOUT, AHB_HRESP
  );
endinterface

// File: rtl/sm3_ahb_regfile.sv
// AHB-Lite slave register file for the SM3 engine: control, status, interrupt mask, DMA addresses and key.
// Define SM3_REG_HRESP_EN to answer unmapped accesses and locked writes with a two-cycle AHB ERROR.
module sm3_ahb_regfile #(
  parameter int unsigned KEY_WORDS = 6,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned HADDR_W   = 6
) (
  input  logic                    AHB_HCLK,
  input  logic                    AHB_HRESET,
  sm3_ahb_regfile_if.slave        ahb,
  input  logic                    SET_STR,
  input  logic                    BUSY,
  output logic                    ENABLE,
  output logic                    START,
  output logic [1:0]              CMDR,
  output logic [32*KEY_WORDS-1:0] KEY,
  output logic [ADDR_W-1:0]       SAR_ADDR,
  output logic [ADDR_W-1:0]       DAR_ADDR,
  output logic [ADDR_W-1:0]       BSR,
  output logic                    CRYPT_INTR
);

  localparam int unsigned IDX_W = HADDR_W - 2;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t IDX_CTRL   = idx_t'(0);
  localparam idx_t IDX_STATUS = idx_t'(1);
  localparam idx_t IDX_IMR    = idx_t'(2);
  localparam idx_t IDX_SAR    = idx_t'(3);
  localparam idx_t IDX_DAR    = idx_t'(4);
  localparam idx_t IDX_BSR    = idx_t'(5);
  localparam idx_t IDX_KEY    = idx_t'(8);

  function automatic logic is_key(input idx_t idx);
    return (idx >= IDX_KEY) && ((idx - IDX_KEY) < idx_t'(KEY_WORDS));
  endfunction

  function automatic logic is_mapped(input idx_t idx);
    return (idx <= IDX_BSR) || is_key(idx);
  endfunction

  function automatic logic is_lockable(input idx_t idx);
    return (idx == IDX_SAR) || (idx == IDX_DAR) || (idx == IDX_BSR) || is_key(idx);
  endfunction

  logic        stall;
  logic        hreadyout;
  logic        hresp;
  logic        accept;
  idx_t        a_idx;
  logic        a_ok;
  logic        dp_valid;
  logic        dp_write;
  idx_t        dp_idx;
  logic        dp_ok;
  logic        dp_done;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_status;
  logic        wr_imr;
  logic        wr_key;
  idx_t        key_sel;
  logic [31:0] hwdata;
  logic [31:0] key_rd;
  logic [31:0] rdata;
  logic        done;
  logic        done_nxt;
  logic        mask;
  logic        mask_nxt;
  logic        unused_bits;

  assign hwdata      = ahb.AHB_HWDATA;
  assign a_idx       = ahb.AHB_HADDR[HADDR_W-1:2];
  assign unused_bits = ^{ahb.AHB_HTRANS[0], ahb.AHB_HADDR[1:0]};

  assign accept = ahb.AHB_HSEL & ahb.AHB_HREADY & ahb.AHB_HTRANS[1] & ~stall;
  // Lock status is sampled with the address so the error decision is known before the data phase.
  assign a_ok   = is_mapped(a_idx) & ~(ahb.AHB_HWRITE & BUSY & is_lockable(a_idx));

`ifdef SM3_REG_HRESP_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERR1,
    ST_ERR2
  } err_state_t;

  err_state_t state;
  err_state_t state_nxt;

  always_ff @(posedge AHB_HCLK or posedge AHB_HRESET) begin
    if (AHB_HRESET) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // ERR1 is the stalled first cycle of the faulty data phase, ERR2 completes it.
  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept && !a_ok) state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        hresp     = 1'b1;
        state_nxt = (accept && !a_ok) ? ST_ERR1 : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign stall = (state == ST_ERR1);
`else
  assign stall     = 1'b0;
  assign hreadyout = 1'b1;
  assign hresp     = 1'b0;
`endif

  assign ahb.AHB_HREADYOUT = hreadyout;
  assign ahb.AHB_HRESP     = hresp;

  always_ff @(posedge AHB_HCLK or posedge AHB_HRESET) begin
    if (AHB_HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_ok    <= 1'b0;
    end else if (ahb.AHB_HREADY && !stall) begin
      dp_valid <= accept;
      dp_write <= ahb.AHB_HWRITE;
      dp_idx   <= a_idx;
      dp_ok    <= a_ok;
    end
  end

  assign dp_done   = dp_valid & ahb.AHB_HREADY;
  assign wr        = dp_done & dp_write & dp_ok;
  assign wr_ctrl   = wr & (dp_idx == IDX_CTRL);
  assign wr_status = wr & (dp_idx == IDX_STATUS);
  assign wr_imr    = wr & (dp_idx == IDX_IMR);
  assign wr_key    = wr & (dp_idx >= IDX_KEY);
  assign key_sel   = dp_idx - IDX_KEY;

  // A simultaneous engine done pulse beats a W1C of DONE.
  always_comb begin
    done_nxt = done;
    if (wr_status && hwdata[0]) done_nxt = 1'b0;
    if (SET_STR)                done_nxt = 1'b1;
    mask_nxt = wr_imr ? hwdata[0] : mask;
  end

  always_ff @(posedge AHB_HCLK or posedge AHB_HRESET) begin
    if (AHB_HRESET) begin
      ENABLE     <= 1'b0;
      CMDR       <= '0;
      START      <= 1'b0;
      SAR_ADDR   <= '0;
      DAR_ADDR   <= '0;
      BSR        <= '0;
      KEY        <= '0;
      done       <= 1'b0;
      mask       <= 1'b0;
      CRYPT_INTR <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ENABLE <= hwdata[0];
        if (!BUSY) CMDR <= hwdata[3:2];
      end
      START      <= wr_ctrl & hwdata[1] & hwdata[0] & ~BUSY;
      done       <= done_nxt;
      mask       <= mask_nxt;
      CRYPT_INTR <= done_nxt & ~mask_nxt;
      if (wr && dp_idx == IDX_SAR) SAR_ADDR <= hwdata[ADDR_W-1:0];
      if (wr && dp_idx == IDX_DAR) DAR_ADDR <= hwdata[ADDR_W-1:0];
      if (wr && dp_idx == IDX_BSR) BSR      <= hwdata[ADDR_W-1:0];
      if (wr_key) begin
        for (int unsigned k = 0; k < KEY_WORDS; k++) begin
          if (key_sel == idx_t'(k)) KEY[32*k +: 32] <= hwdata;
        end
      end
    end
  end

  always_comb begin
    key_rd = '0;
    for (int unsigned k = 0; k < KEY_WORDS; k++) begin
      if (key_sel == idx_t'(k)) key_rd = KEY[32*k +: 32];
    end
    rdata = '0;
    if (dp_valid && !dp_write && dp_ok) begin
      case (dp_idx)
        IDX_CTRL:   rdata = {28'b0, CMDR, 1'b0, ENABLE};
        IDX_STATUS: rdata = {30'b0, BUSY, done};
        IDX_IMR:    rdata = {31'b0, mask};
        IDX_SAR:    rdata = 32'(SAR_ADDR);
        IDX_DAR:    rdata = 32'(DAR_ADDR);
        IDX_BSR:    rdata = 32'(BSR);
        default:    rdata = key_rd;
      endcase
    end
  end

  assign ahb.AHB_HRDATA = rdata;

endmodule

// File: doc/sm3_ahb_regfile.md
Name: sm3_ahb_regfile

Overview:
- Parametrised AHB-Lite slave register file for the SM3 crypto engine.
- Successor of the fixed 13-register control block. It adds the items below:
  - proper AHB address/data phase pipelining;
  - configurable key width and address width;
  - self-clearing START pulse;
  - write-1-to-clear DONE status;
  - write lockout while the engine is busy.
- Sits between the AHB interconnect and the SM3 core/DMA datapath.

Parameters:
- KEY_WORDS, 6: number of 32-bit key words (1..8).
- ADDR_W, 13: width of the SAR_ADDR, DAR_ADDR and BSR registers (1..32).
- HADDR_W, 6: number of AHB address bits decoded (>=6). Bits [1:0] are ignored.

Ports:
- AHB_HCLK, in, 1: single clock. All logic is rising-edge.
- AHB_HRESET, in, 1: asynchronous, active-high reset.
- AHB_HSEL, in, 1: slave select.
- AHB_HTRANS, in, 2: transfer type. Only NONSEQ and SEQ (bit1=1) are valid.
- AHB_HREADY, in, 1: bus ready. Qualifies the address phase.
- AHB_HWRITE, in, 1: 1=write, 0=read.
- AHB_HADDR, in, HADDR_W: byte address.
- AHB_HWDATA, in, 32: write data, valid in the data phase.
- AHB_HRDATA, out, 32: read data.
- AHB_HREADYOUT, out, 1: slave ready.
- AHB_HRESP, out, 1: 0=OKAY, 1=ERROR.
- SET_STR, in, 1: engine done pulse.
- BUSY, in, 1: engine busy level.
- ENABLE, out, 1: engine enable (CTRL[0]).
- START, out, 1: one-cycle start pulse.
- CMDR, out, 2: command (CTRL[3:2]).
- KEY, out, 32*KEY_WORDS: key. Word k occupies bits [32k+31:32k].
- SAR_ADDR, out, ADDR_W: source address.
- DAR_ADDR, out, ADDR_W: destination address.
- BSR, out, ADDR_W: block size.
- CRYPT_INTR, out, 1: interrupt.

Behaviour:
- Register map (word offsets):
  - 0x00 CTRL: [0] EN, [1] START (write-only, reads 0), [3:2] CMD.
  - 0x04 STATUS: [0] DONE (W1C), [1] BUSY (read-only).
  - 0x08 IMR: [0] MASK, 1=masked.
  - 0x0C SAR, 0x10 DAR, 0x14 BSR: low ADDR_W bits; upper bits read 0.
  - 0x20+4k KEY[k], for k<KEY_WORDS.
  - Everything else is unmapped.
- Reset values:
  - All registers and outputs are 0, except AHB_HREADYOUT=1.
  - Any pending transfer is discarded; the error FSM returns to IDLE.
  - Reset mid-transfer aborts it with no register update.
- Address phase: accepted when HSEL & HREADY & HTRANS[1]. The block captures HWRITE, the word index and a mapped/locked flag into phase registers.
- Write data phase: the register updates at the end of the cycle following the address phase, using that cycle's HWDATA. Zero wait states.
- Read data phase: HRDATA is a combinational mux of the captured index during the data phase, and 0 otherwise.
  - Back-to-back write then read of the same register returns the new value.
- START:
  - A write of CTRL with bit1=1 produces START=1 for exactly one cycle, the cycle after the write data phase.
  - It is suppressed if the new EN=0 or BUSY=1 at the data phase.
- Lockout: while BUSY=1, writes to CMD, SAR, DAR, BSR and KEY are ignored. EN, IMR and STATUS remain writable.
- DONE:
  - Set on SET_STR=1.
  - Cleared by writing 1 to STATUS[0].
  - If set and clear occur in the same cycle, set wins.
- CRYPT_INTR = DONE & ~MASK. Registered outputs only; no glitch path from the bus.
- Error FSM (active only with the macro): IDLE -> ERR1 -> ERR2 -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - Entered from a data phase whose address is unmapped or locked.
  - No register update occurs, and the next address phase is not accepted during ERR1.

Optional Feature:
- Macro: SM3_REG_HRESP_EN.
- Defined: unmapped accesses and locked writes get the two-cycle AHB ERROR response via the error FSM.
- Undefined:
  - The FSM is not built; HRESP is tied to 0 and HREADYOUT to 1.
  - Unmapped reads return 0; unmapped and locked writes are silently dropped.

Test Plan:
1. Reset asserted mid-write to KEY[0] -> KEY=0, HREADYOUT=1, and no update after reset release.
2. Write SAR=0x1ABC, then immediately read SAR (back-to-back) -> HRDATA=0x00001ABC with ADDR_W=13; write 0xFFFFFFFF -> reads 0x1FFF.
3. Write CTRL=0x7 with BUSY=0 -> ENABLE=1, CMDR=01, START high for exactly 1 cycle; repeat with BUSY=1 -> no START pulse.
4. With BUSY=1, write KEY[2]=0xDEADBEEF -> KEY[2] unchanged; with the macro, HRESP=1 for 2 cycles and HREADYOUT=0 in the first; without the macro, OKAY.
5. With IMR=0, pulse SET_STR -> DONE=1, CRYPT_INTR=1; write STATUS=0x1 in the same cycle as a SET_STR pulse -> DONE stays 1; a later W1C -> CRYPT_INTR=0.
6. Read offset 0x3C (unmapped, KEY_WORDS=6) -> HRDATA=0; with the macro, ERROR response.
